// File: rtl/tdm_demux_8ch.sv
// Receive-side demultiplexer for an 8-slot TDM link: locks to frame sync,
// steers each beat to its channel and publishes complete frames atomically.
module tdm_demux_8ch #(
  parameter int unsigned DW               = 1,
  parameter bit          SYNC_EVERY_FRAME = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  input  logic            frame_sync,
  output logic [8*DW-1:0] ch_out,
  output logic            frame_valid,
  output logic            locked,
  output logic [2:0]      slot,
  output logic            sync_err
);

  localparam int unsigned NCH = 8;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [2:0]        slot_d;
  logic [DW-1:0]     cap_q [NCH];
  logic [DW-1:0]     cap_d [NCH];
  logic [8*DW-1:0]   ch_out_d;
  logic              frame_valid_d;
  logic              sync_err_d;

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot        <= 3'd0;
      cap_q       <= '{default: '0};
      ch_out      <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot        <= slot_d;
      cap_q       <= cap_d;
      ch_out      <= ch_out_d;
      frame_valid <= frame_valid_d;
      locked      <= (state_d == LOCKED);
      sync_err    <= sync_err_d;
    end
  end

  // Next-state: slot tracking, sync checking and frame publication
  always_comb begin
    state_d       = state_q;
    slot_d        = slot;
    cap_d         = cap_q;
    ch_out_d      = ch_out;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            cap_d[0] = din;
            slot_d   = 3'd1;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && (slot != 3'd0)) begin
            // Misaligned sync restarts the frame on this beat
            sync_err_d = 1'b1;
            cap_d[0]   = din;
            slot_d     = 3'd1;
          end else if (SYNC_EVERY_FRAME && !frame_sync && (slot == 3'd0)) begin
            sync_err_d = 1'b1;
            slot_d     = 3'd0;
            state_d    = HUNT;
          end else begin
            cap_d[slot] = din;
            slot_d      = slot + 3'd1;
            if (slot == 3'd7) begin
              frame_valid_d = 1'b1;
              for (int k = 0; k < 7; k++) begin
                ch_out_d[k*DW +: DW] = cap_q[k];
              end
              ch_out_d[7*DW +: DW] = din;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch (DW=1, sync every frame) with a frame
// scoreboard fed at the slot-7 beat and drained on frame_valid.
module tb_tdm_demux_8ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch_out;
  logic       frame_valid;
  logic       locked;
  logic [2:0] slot;
  logic       sync_err;

  int tests  = 0;
  int failed = 0;
  int frames = 0;
  logic [7:0] sbq [$];

  tdm_demux_8ch #(.DW(1), .SYNC_EVERY_FRAME(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_out     (ch_out),
    .frame_valid(frame_valid),
    .locked     (locked),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every published frame must match the oldest expectation
  always @(negedge clk) begin
    if (frame_valid) begin
      frames++;
      if (sbq.size() == 0) begin
        chk("sb_unexpected_frame", 32'(ch_out), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sbq.pop_front();
        chk("sb_frame", 32'(ch_out), 32'(e));
      end
    end
  end

  task automatic beat(input logic d, input logic fs);
    din        = d;
    frame_sync = fs;
    din_valid  = 1'b1;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Sends slots first..last of frame v (channel k = v[k]), sync on slot 0
  task automatic send_frame(input logic [7:0] v, input int first, input int last,
                            input int gap_at, input int gap_len);
    logic [7:0] prev;
    prev = ch_out;
    for (int k = first; k <= last; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          idle();
          chk("gap_slot_hold", 32'(slot), 32'(k));
          chk("gap_ch_hold", 32'(ch_out), 32'(prev));
        end
      end
      if (k == 7) sbq.push_back(v);
      beat(v[k], k == 0);
      chk("beat_sync_err", 32'(sync_err), 32'(0));
      chk("beat_locked", 32'(locked), 32'(1));
      if (k == 7) begin
        chk("frame_valid_pulse", 32'(frame_valid), 32'(1));
        chk("frame_data", 32'(ch_out), 32'(v));
        chk("slot_wrap", 32'(slot), 32'(0));
      end else begin
        chk("no_early_frame", 32'(frame_valid), 32'(0));
        chk("slot_advance", 32'(slot), 32'(k + 1));
        chk("ch_out_hold", 32'(ch_out), 32'(prev));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ch_out", 32'(ch_out), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_slot", 32'(slot), 32'(0));
    chk("rst_frame_valid", 32'(frame_valid), 32'(0));
    chk("rst_sync_err", 32'(sync_err), 32'(0));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat(1'(i & 1), 1'b0);
      chk("hunt_no_frame", 32'(frame_valid), 32'(0));
      chk("hunt_unlocked", 32'(locked), 32'(0));
      chk("hunt_slot", 32'(slot), 32'(0));
    end

    // Acquire: din 1,0,1,1,0,0,1,0 for slots 0..7
    send_frame(8'b0100_1101, 0, 7, -1, 0);
    idle();
    chk("pulse_one_cycle", 32'(frame_valid), 32'(0));
    chk("ch_out_persist", 32'(ch_out), 32'h4D);

    // Back-to-back, with a 3-cycle gap inside frame 2
    send_frame(8'hA5, 0, 7, -1, 0);
    send_frame(8'h3C, 0, 7, 4, 3);

    // Misaligned sync at slot 4
    send_frame(8'h0F, 0, 3, -1, 0);
    beat(1'b1, 1'b1);
    chk("mis_sync_err", 32'(sync_err), 32'(1));
    chk("mis_no_frame", 32'(frame_valid), 32'(0));
    chk("mis_slot", 32'(slot), 32'(1));
    chk("mis_locked", 32'(locked), 32'(1));
    chk("mis_ch_out", 32'(ch_out), 32'h3C);
    send_frame(8'b1001_0111, 1, 7, -1, 0);

    // Missing sync at slot 0
    send_frame(8'h96, 0, 7, -1, 0);
    beat(1'b1, 1'b0);
    chk("miss_sync_err", 32'(sync_err), 32'(1));
    chk("miss_locked", 32'(locked), 32'(0));
    chk("miss_slot", 32'(slot), 32'(0));
    chk("miss_no_frame", 32'(frame_valid), 32'(0));
    chk("miss_ch_out", 32'(ch_out), 32'h96);
    idle();
    chk("miss_err_pulse", 32'(sync_err), 32'(0));
    chk("miss_stay_hunt", 32'(locked), 32'(0));

    // Reset mid-frame at slot 5, then reacquire with 0xFF
    send_frame(8'h00, 0, 4, -1, 0);
    chk("pre_rst_slot", 32'(slot), 32'(5));
    rst_n = 1'b0;
    #1;
    chk("arst_ch_out", 32'(ch_out), 32'(0));
    chk("arst_locked", 32'(locked), 32'(0));
    chk("arst_slot", 32'(slot), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'hFF, 0, 7, -1, 0);
    idle();

    chk("sb_drained", 32'(sbq.size()), 32'(0));
    chk("frame_count", 32'(frames), 32'(6));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
